slot_copy_agu: RTL
==================

Name: slot_copy_agu

Overview:
- Sequencer that copies one 18-word operand slot to another inside the cryptoprocessor's single-port-read / single-port-write operand RAM.
- Drives the 4-bit slot index into two slot-to-base-address ROMs: one for the source slot, one for the destination slot.
- Each ROM maps slot k to base address 18*k.
- Registers the returned base addresses, then issues a pipelined burst of 18 reads and 18 writes.
- Sits directly downstream of the slot base-address ROMs and upstream of the operand RAM. The top-level controller uses it for register moves, e.g. T <- X before a Frobenius or add step.

Parameters:
- WORDS, 18, words per operand slot (burst length).
- DW, 16, RAM data width.
- AW, 8, RAM address width (max address 13*18+17 = 251).
- NSLOTS, 14, number of valid slots (0..13).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle request; sampled only in IDLE.
- src_slot  in  4  source slot index.
- dst_slot  in  4  destination slot index.
- rom_addr_src  out  4  address to source base ROM.
- rom_data_src  in  8  source base address (combinational ROM output).
- rom_addr_dst  out  4  address to destination base ROM.
- rom_data_dst  in  8  destination base address.
- ram_re  out  1  read enable.
- ram_raddr  out  AW  read address.
- ram_rdata  in  DW  read data, valid exactly 1 cycle after ram_re.
- ram_we  out  1  write enable.
- ram_waddr  out  AW  write address.
- ram_wdata  out  DW  write data.
- busy  out  1  high while a copy is in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse, asserted together with done, on an invalid slot.

Behaviour:
- Reset (async, rst_n=0): state IDLE.
  - All outputs 0: ram_re, ram_we, busy, done, err, all address outputs and ram_wdata.
  - Internal counter and captured slot/base registers cleared.
  - Takes effect immediately, including mid-burst. A burst interrupted by reset is abandoned and never resumed.
- States: IDLE, LOOKUP, BURST, DRAIN, FINISH.
- IDLE:
  - On start=1: capture src_slot and dst_slot; go to LOOKUP; busy=1 from the next cycle.
  - rom_addr_src/rom_addr_dst are driven from the captured registers at all times.
- LOOKUP (1 cycle):
  - If either captured slot >= NSLOTS: go to FINISH with err flagged. No RAM access occurs.
  - Otherwise latch rom_data_src into src_base and rom_data_dst into dst_base, clear counter i=0, go to BURST.
- BURST (WORDS cycles, i = 0..WORDS-1):
  - ram_re=1, ram_raddr = src_base + i.
  - From the second BURST cycle onward: ram_we=1, ram_waddr = dst_base + (i-1), ram_wdata = ram_rdata.
  - After i = WORDS-1, go to DRAIN.
- DRAIN (1 cycle): ram_re=0; ram_we=1 for the final word at dst_base + WORDS-1.
- FINISH (1 cycle): busy=0, done=1, err=1 only if flagged; return to IDLE.
- Timing for a valid copy with start at cycle 0:
  - LOOKUP: cycle 1.
  - Reads: cycles 2..19.
  - Writes: cycles 3..20.
  - done: cycle 21.
  - busy: high cycles 1..20.
  - Error path: done+err at cycle 2; busy high only in cycle 1.
- Address arithmetic is AW bits, unsigned, no wrap (max 251). The counter is 5 bits.
- start while not IDLE is ignored; no queueing.
- start in the FINISH cycle is ignored; start is accepted again from the next IDLE cycle.
- src_slot == dst_slot is legal: it performs read-then-rewrite of identical data, and each word is read before it is written.
- ram_re and ram_we are never both asserted to the same address in the same cycle; the write lags the read by one word.
- ram_wdata holds its last value when ram_we=0.

Test Plan:
- Reset, idle: rst_n=0 then 1, no start -> all outputs 0, state IDLE for 10 cycles.
- Valid copy src=2, dst=5 (ROM returns 36 and 90), RAM words 36..53 preloaded 0x1000..0x1011:
  - ram_raddr 36..53 in cycles 2..19.
  - ram_waddr 90..107 in cycles 3..20, with wdata 0x1000..0x1011.
  - done pulse at cycle 21; busy high cycles 1..20.
- Boundary slot src=13, dst=0: reads 234..251, writes 0..17, no address overflow.
- Invalid slot src=14: at cycle 2 done=1 and err=1; ram_re and ram_we never asserted.
- Start while busy: second start at cycle 5 with dst=7 -> ignored; writes still go to the first dst; exactly one done.
- Reset mid-burst: rst_n=0 at cycle 10 -> same cycle ram_re=ram_we=busy=0; after release, a new start performs a full 18-word copy.

Source files
------------

// File: rtl/slot_copy_agu.sv
// Slot-to-slot copy sequencer for the operand RAM: looks up both slot base
// addresses, then streams WORDS reads with the matching writes one word behind.
module slot_copy_agu #(
    parameter int WORDS  = 18,
    parameter int DW     = 16,
    parameter int AW     = 8,
    parameter int NSLOTS = 14
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [3:0]    src_slot,
    input  logic [3:0]    dst_slot,
    output logic [3:0]    rom_addr_src,
    input  logic [AW-1:0] rom_data_src,
    output logic [3:0]    rom_addr_dst,
    input  logic [AW-1:0] rom_data_dst,
    output logic          ram_re,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    output logic          ram_we,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_BURST  = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam logic [3:0] LP_NSLOTS = 4'(NSLOTS);
    localparam logic [4:0] LP_LAST   = 5'(WORDS - 1);

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_src_slot;
    logic [3:0]    r_dst_slot;
    logic [AW-1:0] r_src_base;
    logic [AW-1:0] r_dst_base;
    logic [4:0]    r_cnt;
    logic          r_err;
    logic [DW-1:0] r_wdata_hold;

    logic          w_bad_slot;
    logic [AW-1:0] w_cnt_ext;
    logic          w_re;
    logic          w_we;

    assign w_bad_slot = (r_src_slot >= LP_NSLOTS) || (r_dst_slot >= LP_NSLOTS);
    assign w_cnt_ext  = {{(AW-5){1'b0}}, r_cnt};

    // Handshake: start is a one-cycle request honoured only in IDLE; busy
    // covers LOOKUP..DRAIN and done (with err on a bad slot) pulses once after.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_src_slot   <= '0;
            r_dst_slot   <= '0;
            r_src_base   <= '0;
            r_dst_base   <= '0;
            r_cnt        <= '0;
            r_err        <= 1'b0;
            r_wdata_hold <= '0;
        end else begin
            r_state <= w_next;
            if (w_we) begin
                r_wdata_hold <= ram_rdata;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src_slot <= src_slot;
                        r_dst_slot <= dst_slot;
                        r_err      <= 1'b0;
                    end
                end
                S_LOOKUP: begin
                    r_err <= w_bad_slot;
                    if (!w_bad_slot) begin
                        r_src_base <= rom_data_src;
                        r_dst_base <= rom_data_dst;
                        r_cnt      <= '0;
                    end
                end
                S_BURST: begin
                    r_cnt <= r_cnt + 5'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_LOOKUP;
            S_LOOKUP: w_next = w_bad_slot ? S_FINISH : S_BURST;
            S_BURST:  if (r_cnt == LP_LAST) w_next = S_DRAIN;
            S_DRAIN:  w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // The write trails the read by one word, so in DRAIN the counter already
    // equals WORDS and cnt-1 names the final word.
    always_comb begin
        w_re      = (r_state == S_BURST);
        w_we      = ((r_state == S_BURST) && (r_cnt != 5'd0)) || (r_state == S_DRAIN);
        ram_re    = w_re;
        ram_we    = w_we;
        ram_raddr = '0;
        ram_waddr = '0;
        if (w_re) begin
            ram_raddr = r_src_base + w_cnt_ext;
        end
        if (w_we) begin
            ram_waddr = r_dst_base + w_cnt_ext - {{(AW-1){1'b0}}, 1'b1};
        end
        ram_wdata = w_we ? ram_rdata : r_wdata_hold;
        busy      = (r_state == S_LOOKUP) || (r_state == S_BURST) || (r_state == S_DRAIN);
        done      = (r_state == S_FINISH);
        err       = (r_state == S_FINISH) && r_err;
    end

    assign rom_addr_src = r_src_slot;
    assign rom_addr_dst = r_dst_slot;
    assign dbg_state    = r_state;

endmodule
